// File: rtl/wb_rr_arbiter_pkg.sv
// Shared constants and helpers for the two-master round-robin Wishbone arbiter:
// FSM state encodings, master indices, default watchdog read data.
package wb_rr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_TOUT = 2'd2;

    localparam int M_CPU = 0;
    localparam int M_DMA = 1;
    localparam int N_MST = 2;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    // One-hot winner among the requesters; rr_ptr names the favoured master on a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic rr_ptr);
        if (req == 2'b11) begin
            return rr_ptr ? 2'b10 : 2'b01;
        end
        return req;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Single-transfer Wishbone bus bundle; the master modport drives the request side,
// the slave modport drives ack and read data.
interface wb_rr_arbiter_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  ack, dat_r
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output ack, dat_r
    );

endinterface

// File: rtl/wb_arb_wdog.sv
// Watchdog counter for the arbiter: counts BUSY cycles without ack and flags
// when the limit is reached. Instantiated only when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_wdog
    import wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter (m0 = CPU, m1 = DMA) in front of one slave port.
// Define WB_ARB_TIMEOUT_EN to add the watchdog that completes hung cycles with ERR_DATA.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TO_W        = 8,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    wb_rr_arbiter_if.slave  m0_if,
    wb_rr_arbiter_if.slave  m1_if,
    wb_rr_arbiter_if.master s_if,
    output logic [1:0]      gnt_o,
    output logic            to_err_o
);

    logic [1:0]       state_q, state_d;
    logic [N_MST-1:0] gnt_q, gnt_d;
    logic             rr_q, rr_d;

    wb_req_t          req_v [N_MST];
    logic [N_MST-1:0] req;
    logic [N_MST-1:0] ack_v;
    logic [31:0]      dat_v [N_MST];
    logic [31:0]      rsp_dat;
    wb_req_t          g_req;
    logic             g_idx;
    logic             busy;
    logic             tout;

    assign req_v[M_CPU] = '{cyc: m0_if.cyc, stb: m0_if.stb, we: m0_if.we,
                            sel: m0_if.sel, adr: m0_if.adr, dat: m0_if.dat_w};
    assign req_v[M_DMA] = '{cyc: m1_if.cyc, stb: m1_if.stb, we: m1_if.we,
                            sel: m1_if.sel, adr: m1_if.adr, dat: m1_if.dat_w};

    assign busy  = (state_q == ST_BUSY);
    assign g_idx = gnt_q[M_DMA];
    assign g_req = req_v[g_idx];

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_expire;

    assign tout     = (state_q == ST_TOUT);
    assign to_err_o = tout;
    assign rsp_dat  = tout ? ERR_DATA : s_if.dat_r;

    wb_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_wdog (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .clr_i    (~busy),
        .inc_i    (busy & ~s_if.ack),
        .expire_o (wd_expire)
    );
`else
    assign tout     = 1'b0;
    assign to_err_o = 1'b0;
    assign rsp_dat  = s_if.dat_r;
`endif

    // Acks and read data reach only the granted master; everyone else sees zeros.
    generate
        for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
            assign req[gi]   = req_v[gi].cyc & req_v[gi].stb;
            assign ack_v[gi] = gnt_q[gi] & ((busy & s_if.ack) | tout);
            assign dat_v[gi] = ack_v[gi] ? rsp_dat : '0;
        end
    endgenerate

    assign m0_if.ack   = ack_v[M_CPU];
    assign m0_if.dat_r = dat_v[M_CPU];
    assign m1_if.ack   = ack_v[M_DMA];
    assign m1_if.dat_r = dat_v[M_DMA];

    assign s_if.cyc   = busy & g_req.cyc;
    assign s_if.stb   = busy & g_req.stb;
    assign s_if.we    = busy & g_req.we;
    assign s_if.sel   = busy ? g_req.sel : '0;
    assign s_if.adr   = busy ? g_req.adr : '0;
    assign s_if.dat_w = busy ? g_req.dat : '0;

    assign gnt_o = gnt_q;

    // Any way out of a grant (ack, abort, watchdog) hands priority to the other master.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = rr_pick(req, rr_q);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_if.ack || !g_req.cyc) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    rr_d    = ~g_idx;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = ST_TOUT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_TOUT: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                rr_d    = ~g_idx;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

endmodule
